// File: rtl/sad_min_select_if.sv
// sad_min_select_if: SAD stream in, best-match result out, between the PE array and the selector
interface sad_min_select_if #(
    parameter int SAD_W = 12,
    parameter int MV_W  = 5
);
    logic                    start;
    logic                    sad_valid;
    logic [SAD_W-1:0]        sad;
    logic                    busy;
    logic                    done;
    logic [SAD_W-1:0]        best_sad;
    logic signed [MV_W-1:0]  best_mvx;
    logic signed [MV_W-1:0]  best_mvy;
    modport master (output start, sad_valid, sad, input busy, done, best_sad, best_mvx, best_mvy);
    modport slave  (input start, sad_valid, sad, output busy, done, best_sad, best_mvx, best_mvy);
endinterface

// File: rtl/sad_min_select.sv
// sad_min_select: scans a raster-ordered candidate SAD window and reports the minimum SAD and its motion vector
module sad_min_select #(
    parameter int SAD_W    = 12,
    parameter int SEARCH_W = 8,
    parameter int SEARCH_H = 8,
    parameter int MV_W     = 5
) (
    input logic              clk,
    input logic              rst,
    sad_min_select_if.slave  sad_if
);
    localparam int CW = $clog2(SEARCH_W);
    localparam int RW = $clog2(SEARCH_H);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t                 state_q, state_d;
    logic [CW-1:0]          col_q, col_d, bcol_q, bcol_d;
    logic [RW-1:0]          row_q, row_d, brow_q, brow_d;
    logic [SAD_W-1:0]       min_q, min_d, best_sad_q, best_sad_d;
    logic signed [MV_W-1:0] best_mvx_q, best_mvx_d, best_mvy_q, best_mvy_d;
    logic                   accept, better, last_col, last_row;
    logic [SAD_W-1:0]       cand_min;
    logic [CW-1:0]          cand_col;
    logic [RW-1:0]          cand_row;
    assign accept   = (state_q == SCAN) && sad_if.sad_valid;
    assign better   = sad_if.sad < min_q;
    assign last_col = col_q == CW'(SEARCH_W - 1);
    assign last_row = row_q == RW'(SEARCH_H - 1);
    assign cand_min = better ? sad_if.sad : min_q;
    assign cand_col = better ? col_q : bcol_q;
    assign cand_row = better ? row_q : brow_q;
    assign sad_if.busy     = state_q == SCAN;
    assign sad_if.done     = state_q == DONE;
    assign sad_if.best_sad = best_sad_q;
    assign sad_if.best_mvx = best_mvx_q;
    assign sad_if.best_mvy = best_mvy_q;
    // Next state, scan counters, running minimum; the result is loaded on the last accept so it is visible with done
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        bcol_d     = bcol_q;
        brow_d     = brow_q;
        min_d      = min_q;
        best_sad_d = best_sad_q;
        best_mvx_d = best_mvx_q;
        best_mvy_d = best_mvy_q;
        case (state_q)
            SCAN: begin
                if (accept) begin
                    min_d  = cand_min;
                    bcol_d = cand_col;
                    brow_d = cand_row;
                    col_d  = last_col ? '0 : col_q + 1'b1;
                    row_d  = last_col ? (last_row ? '0 : row_q + 1'b1) : row_q;
                    if (last_col && last_row) begin
                        state_d    = DONE;
                        best_sad_d = cand_min;
                        best_mvx_d = MV_W'(cand_col) - MV_W'(SEARCH_W / 2);
                        best_mvy_d = MV_W'(cand_row) - MV_W'(SEARCH_H / 2);
                    end
                end
            end
            default: begin
                state_d = sad_if.start ? SCAN : IDLE;
                if (sad_if.start) begin
                    col_d  = '0;
                    row_d  = '0;
                    bcol_d = '0;
                    brow_d = '0;
                    min_d  = '1;
                end
            end
        endcase
    end
    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    // Datapath registers: scan position, running best, published result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            bcol_q     <= '0;
            brow_q     <= '0;
            min_q      <= '1;
            best_sad_q <= '0;
            best_mvx_q <= '0;
            best_mvy_q <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            bcol_q     <= bcol_d;
            brow_q     <= brow_d;
            min_q      <= min_d;
            best_sad_q <= best_sad_d;
            best_mvx_q <= best_mvx_d;
            best_mvy_q <= best_mvy_d;
        end
    end
endmodule

// File: tb/tb_sad_min_select.sv
// tb_sad_min_select: directed vectors for the SAD minimum selector
module tb_sad_min_select;
    logic clk = 0;
    logic rst = 0;
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   d0;
    logic [11:0] sads [64];
    sad_min_select_if #(.SAD_W(12), .MV_W(5)) bus ();
    sad_min_select #(.SAD_W(12), .SEARCH_W(8), .SEARCH_H(8), .MV_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .sad_if (bus)
    );
    always #5 clk = ~clk;
    // done is registered, so counting at the rising edge sees the previous cycle's value
    always @(posedge clk) if (bus.done) done_cnt++;
    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic fill(input int base);
        for (int i = 0; i < 64; i++) sads[i] = 12'(base);
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_sad"}, int'(bus.best_sad), 0);
        check({tag, "_mvx"}, int'(bus.best_mvx), 0);
        check({tag, "_mvy"}, int'(bus.best_mvy), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
    endtask
    task automatic mid_reset(input string tag);
        @(posedge clk);
        #2 rst = 1;
        #1 check_zero(tag);
        @(negedge clk);
        rst = 0;
    endtask
    task automatic search(input bit skip_start, input bit gaps, input bit noise, input int n);
        if (!skip_start) begin
            bus.start = 1;
            @(negedge clk);
            bus.start = 0;
        end
        check("busy_scan", int'(bus.busy), 1);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin
                bus.sad_valid = 0;
                @(negedge clk);
            end
            bus.sad_valid = 1;
            bus.sad       = sads[i];
            bus.start     = noise && i == 10;
            @(negedge clk);
        end
        bus.sad_valid = 0;
        bus.start     = 0;
    endtask
    task automatic finish_check(input string tag, input int es, input int ex, input int ey, input bit chain);
        check({tag, "_done"}, int'(bus.done), 1);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_sad"}, int'(bus.best_sad), es);
        check({tag, "_mvx"}, int'(bus.best_mvx), ex);
        check({tag, "_mvy"}, int'(bus.best_mvy), ey);
        bus.start = chain;
        @(negedge clk);
        bus.start = 0;
        check({tag, "_done_clr"}, int'(bus.done), 0);
        check({tag, "_busy_after"}, int'(bus.busy), int'(chain));
    endtask
    initial begin
        bus.start = 0;
        bus.sad_valid = 0;
        bus.sad = '0;
        #2 rst = 1;
        #1 check_zero("por");
        repeat (2) @(negedge clk);
        rst = 0;
        fill(500);
        sads[5*8+3] = 12;
        search(0, 0, 0, 64);
        finish_check("single", 12, -1, 1, 0);
        mid_reset("rst_mid");
        fill(100);
        sads[0] = 7;
        sads[63] = 7;
        d0 = done_cnt;
        search(0, 1, 0, 64);
        finish_check("tie", 7, -4, -4, 0);
        @(negedge clk);
        check("tie_done_cnt", done_cnt - d0, 1);
        fill(4095);
        sads[63] = 0;
        search(0, 0, 0, 64);
        finish_check("last", 0, 3, 3, 0);
        fill(500);
        sads[5*8+3] = 12;
        search(0, 1, 1, 64);
        finish_check("noisy", 12, -1, 1, 1);
        fill(4095);
        search(1, 0, 0, 64);
        finish_check("chain_ones", 4095, -4, -4, 0);
        bus.sad_valid = 1;
        bus.sad = '0;
        repeat (3) @(negedge clk);
        bus.sad_valid = 0;
        check("idle_busy", int'(bus.busy), 0);
        check("idle_sad", int'(bus.best_sad), 4095);
        check("idle_mvx", int'(bus.best_mvx), -4);
        check("idle_mvy", int'(bus.best_mvy), -4);
        fill(200);
        sads[5] = 1;
        d0 = done_cnt;
        search(0, 0, 0, 30);
        mid_reset("abort");
        @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        sads[5] = 200;
        sads[2*8+6] = 3;
        search(0, 1, 0, 64);
        finish_check("after_abort", 3, 2, -2, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
